// File: rtl/cpu_control_if.sv
// rtl/cpu_control_if.sv - fetch, decode-control and register-file address bundle for cpu_control
interface cpu_control_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] PC;
    logic                INSTR_REQ;
    logic                INSTR_VALID;
    logic [31:0]         INSTRUCTION;
    logic                ZERO;
    logic                WRITE;
    logic [2:0]          INADDRESS;
    logic [2:0]          OUT1ADDRESS;
    logic [2:0]          OUT2ADDRESS;
    logic [7:0]          IMMEDIATE;
    logic [2:0]          ALUOP;
    logic                IMM_SEL;
    logic                NEG_SEL;
    logic                ILLEGAL;

    modport master (
        output PC, INSTR_REQ, WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
               IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, ILLEGAL,
        input  INSTR_VALID, INSTRUCTION, ZERO
    );

    modport slave (
        input  PC, INSTR_REQ, WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
               IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, ILLEGAL,
        output INSTR_VALID, INSTRUCTION, ZERO
    );
endinterface

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - PC owner, fetch handshake and instruction decoder for the 8-bit CPU
// Optional illegal-opcode trap enabled by defining CPU_CTRL_ILLEGAL_TRAP_EN.
module cpu_control #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    cpu_control_if.master bus
);
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                instr_req_q, instr_req_d;
    logic                write_q, write_d;
    logic [2:0]          inaddr_q, inaddr_d;
    logic [2:0]          out1_q, out1_d;
    logic [2:0]          out2_q, out2_d;
    logic [7:0]          imm_q, imm_d;
    logic [2:0]          aluop_q, aluop_d;
    logic                imm_sel_q, imm_sel_d;
    logic                neg_sel_q, neg_sel_d;
    logic [7:0]          op_q, op_d;
    logic [7:0]          offset_q, offset_d;
    logic                taken_q, taken_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic                illegal_q, illegal_d;
`endif

    logic [7:0]          in_op;
    logic                fetch_fire;
    logic [2:0]          dec_aluop;
    logic                dec_imm_sel;
    logic                dec_neg_sel;
    logic [PC_WIDTH-1:0] br_offset;
    logic [PC_WIDTH-1:0] pc_next;
    logic                unused_src1_hi;

    assign in_op          = bus.INSTRUCTION[31:24];
    assign fetch_fire     = (state_q == S_FETCH) && bus.INSTR_VALID;
    assign unused_src1_hi = ^bus.INSTRUCTION[15:11];

    // Byte offset is in words: sign-extend then scale by 4.
    assign br_offset = {{(PC_WIDTH-10){offset_q[7]}}, offset_q, 2'b00};
    assign pc_next   = pc_q + PC_WIDTH'(4) + (taken_q ? br_offset : '0);

    always_comb begin
        dec_aluop   = ALU_FWD;
        dec_imm_sel = 1'b0;
        dec_neg_sel = 1'b0;
        case (in_op)
            OP_LOADI: dec_imm_sel = 1'b1;
            OP_ADD:   dec_aluop   = ALU_ADD;
            OP_SUB, OP_BEQ: begin
                dec_aluop   = ALU_ADD;
                dec_neg_sel = 1'b1;
            end
            OP_AND:   dec_aluop   = ALU_AND;
            OP_OR:    dec_aluop   = ALU_OR;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.INSTR_VALID) state_d = S_DECODE;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_DECODE: state_d = (op_q > OP_BEQ) ? S_TRAP : S_EXEC;
            S_TRAP:   state_d = S_TRAP;
`else
            S_DECODE: state_d = S_EXEC;
`endif
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        instr_req_d = instr_req_q;
        write_d     = write_q;
        inaddr_d    = inaddr_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        imm_d       = imm_q;
        aluop_d     = aluop_q;
        imm_sel_d   = imm_sel_q;
        neg_sel_d   = neg_sel_q;
        op_d        = op_q;
        offset_d    = offset_q;
        taken_d     = taken_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif

        // All controls are captured on the DECODE entry edge and held through WB.
        if (fetch_fire) begin
            instr_req_d = 1'b0;
            op_d        = in_op;
            offset_d    = bus.INSTRUCTION[23:16];
            inaddr_d    = bus.INSTRUCTION[18:16];
            out1_d      = bus.INSTRUCTION[10:8];
            out2_d      = bus.INSTRUCTION[2:0];
            imm_d       = bus.INSTRUCTION[7:0];
            aluop_d     = dec_aluop;
            imm_sel_d   = dec_imm_sel;
            neg_sel_d   = dec_neg_sel;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            if (in_op > OP_BEQ) illegal_d = 1'b1;
`endif
        end

        // ZERO is only looked at on the EXEC->WB edge so later glitches are harmless.
        if (state_q == S_EXEC) begin
            write_d = (op_q <= OP_OR);
            taken_d = (op_q == OP_J) || ((op_q == OP_BEQ) && bus.ZERO);
        end

        if (state_q == S_WB) begin
            write_d     = 1'b0;
            pc_d        = pc_next;
            instr_req_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q        <= RESET_PC;
            instr_req_q <= 1'b1;
            write_q     <= 1'b0;
            inaddr_q    <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            imm_q       <= '0;
            aluop_q     <= ALU_FWD;
            imm_sel_q   <= 1'b0;
            neg_sel_q   <= 1'b0;
            op_q        <= '0;
            offset_q    <= '0;
            taken_q     <= 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            instr_req_q <= instr_req_d;
            write_q     <= write_d;
            inaddr_q    <= inaddr_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            imm_q       <= imm_d;
            aluop_q     <= aluop_d;
            imm_sel_q   <= imm_sel_d;
            neg_sel_q   <= neg_sel_d;
            op_q        <= op_d;
            offset_q    <= offset_d;
            taken_q     <= taken_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign bus.PC          = pc_q;
    assign bus.INSTR_REQ   = instr_req_q;
    assign bus.WRITE       = write_q;
    assign bus.INADDRESS   = inaddr_q;
    assign bus.OUT1ADDRESS = out1_q;
    assign bus.OUT2ADDRESS = out2_q;
    assign bus.IMMEDIATE   = imm_q;
    assign bus.ALUOP       = aluop_q;
    assign bus.IMM_SEL     = imm_sel_q;
    assign bus.NEG_SEL     = neg_sel_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign bus.ILLEGAL     = illegal_q;
`else
    assign bus.ILLEGAL     = 1'b0;
`endif
endmodule

// File: doc/cpu_control.md
# cpu_control

Instruction sequencer and decoder for the 8-bit single-issue CPU, sitting directly upstream of the 8x8 register file. It owns the PC, fetches 32-bit instructions over a request/valid handshake, and decodes them into register-file addresses, the WRITE strobe, the immediate and ALU controls. It also resolves `j`/`beq` using the ALU ZERO flag.

## Interface
- `PC_WIDTH`, 32: width of the program counter and fetch address.
- `RESET_PC`, 0: PC value loaded on reset.

- `CLK` in 1: clock; all state updates on posedge.
- `RESET` in 1: asynchronous, active-low reset; clock is `CLK`, reset is `RESET`.
- `PC` out `PC_WIDTH`: fetch address.
- `INSTR_REQ` out 1: fetch request.
- `INSTR_VALID` in 1: `INSTRUCTION` valid this cycle.
- `INSTRUCTION` in 32: fields are OP[31:24], DEST/OFFSET[23:16], SRC1[15:8], SRC2/IMM[7:0]. Only low 3 bits of each register field are used.
- `ZERO` in 1: ALU result == 0.
- `WRITE` out 1: register-file write enable.
- `INADDRESS`, `OUT1ADDRESS`, `OUT2ADDRESS` out 3: register-file addresses.
- `IMMEDIATE` out 8: INSTRUCTION[7:0] of the latched instruction.
- `ALUOP` out 3: 000 FWD, 001 ADD, 010 AND, 011 OR.
- `IMM_SEL` out 1: ALU operand 2 = `IMMEDIATE`.
- `NEG_SEL` out 1: ALU operand 2 is two's-complement negated.
- `ILLEGAL` out 1: sticky illegal-opcode flag.

## Operation
- Opcodes:
  - 0x00 loadi: rd = imm.
  - 0x01 mov: rd = rs2.
  - 0x02 add.
  - 0x03 sub: ADD with NEG_SEL.
  - 0x04 and.
  - 0x05 or.
  - 0x06 j.
  - 0x07 beq: SUB of rs1, rs2; taken when ZERO = 1.
- FSM states FETCH, DECODE, EXEC, WB.
  - FETCH: INSTR_REQ = 1. On a posedge with INSTR_VALID = 1, latch INSTRUCTION, drop INSTR_REQ and go to DECODE. Otherwise stay in FETCH with PC held.
  - DECODE: drive OUT1ADDRESS = SRC1, OUT2ADDRESS = SRC2, INADDRESS = DEST, ALUOP/IMM_SEL/NEG_SEL. Go to EXEC.
  - EXEC: controls held; register-file outputs and ALU settle. ZERO is sampled at the end of EXEC. Go to WB.
  - WB: WRITE = 1 for opcodes 0x00–0x05, 0 otherwise. Update PC, then go to FETCH.
- PC update:
  - Default: PC + 4.
  - j, and beq when taken: PC + 4 + (sign_extend(OFFSET) << 2).
  - Arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- Controls are registered outputs. They change only on the DECODE entry edge and remain stable through WB.
- Reset values: PC = RESET_PC, INSTR_REQ = 1 (the state is FETCH), WRITE = 0, all addresses 0, IMMEDIATE 0, ALUOP 000, IMM_SEL 0, NEG_SEL 0, ILLEGAL 0.
- Reset asserted mid-instruction aborts it immediately. No WRITE is issued and the PC is not updated.

## Timing
- Minimum 4 cycles per instruction: FETCH (1 with INSTR_VALID already high), DECODE, EXEC, WB.
- Each cycle of INSTR_VALID low during FETCH adds one cycle.
- WRITE is high for exactly one cycle per register-writing instruction.
- The register file writes on the WB→FETCH posedge.
- INSTR_VALID is ignored outside FETCH.
- A new INSTR_REQ is raised in the cycle after WB, with the updated PC already on `PC`.
- Branch decision uses ZERO as sampled at the last EXEC posedge. Later ZERO glitches have no effect.

## Configuration
- `CPU_CTRL_ILLEGAL_TRAP_EN` defined: an opcode > 0x07 sets ILLEGAL = 1 in DECODE.
  - The FSM then parks in a TRAP state with INSTR_REQ = 0 and WRITE = 0, and PC frozen at the faulting address.
  - Only reset exits TRAP.
- Not defined: opcodes > 0x07 execute as NOP (no WRITE, PC + 4, normal 4-cycle sequence), and ILLEGAL is tied to 0.

## Test plan
- Reset release with INSTR_VALID held high, then `loadi r2, 0x2A` (0x0002002A) → PC = 0 at the first fetch. WRITE pulses once, 3 cycles after the fetch edge, with INADDRESS = 2 and IMMEDIATE = 0x2A, IMM_SEL = 1. PC = 4 at the next fetch.
- `sub r3, r1, r2` (0x03030102) → OUT1ADDRESS = 1, OUT2ADDRESS = 2, ALUOP = 001, NEG_SEL = 1, IMM_SEL = 0; WRITE to INADDRESS = 3.
- `beq` with OFFSET 0xFE at PC = 0x10: ZERO = 1 → next PC = 0x0C; ZERO = 0 → next PC = 0x14; WRITE stays 0 in both cases.
- INSTR_VALID held low for 5 cycles in FETCH → INSTR_REQ stays high, PC is stable, no state advance; the instruction completes 4 cycles after INSTR_VALID rises.
- RESET pulsed low during EXEC of an `add` → no WRITE is issued and all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
- Opcode 0xFF: with the macro, ILLEGAL = 1 and INSTR_REQ = 0 permanently until reset. Without it, the instruction runs as a NOP and PC advances by 4.
